// File: rtl/fe_mul.sv
// Sequential multiplier over GF(2^255 - 19): one 255x17 partial product per
// cycle for 15 cycles, then four fixed reduction steps to a canonical result.
module fe_mul (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic         done,
  output logic [254:0] out
);

  localparam logic [255:0] P =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [3:0] LAST_LIMB = 4'd14;
  localparam logic [1:0] LAST_RED  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RED} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mstep_q, mstep_d;
  logic [1:0]    rstep_q, rstep_d;
  logic          done_q, done_d;
  logic [254:0]  out_q, out_d;
  logic [254:0]  a_q, a_d;
  logic [254:0]  b_q, b_d;
  logic [509:0]  acc_q, acc_d;

  logic [7:0]    shamt;
  logic [16:0]   b_limb;
  logic [271:0]  pp;

  // 2^255 == 19 (mod p): fold the high half back in with a x19 multiply.
  function automatic logic [259:0] fold_wide(input logic [509:0] x);
    return {5'd0, x[254:0]} + 260'(x[509:255]) * 260'd19;
  endfunction

  function automatic logic [255:0] fold_narrow(input logic [259:0] x);
    return {1'b0, x[254:0]} + 256'(x[259:255]) * 256'd19;
  endfunction

  // Input is below 2^255 + 589, so a single conditional subtract suffices.
  function automatic logic [254:0] canon(input logic [255:0] x);
    logic [255:0] diff;
    diff = x - P;
    return (x >= P) ? diff[254:0] : x[254:0];
  endfunction

  assign shamt  = 8'(mstep_q) * 8'd17;
  assign b_limb = b_q[shamt +: 17];
  assign pp     = 272'(a_q) * 272'(b_limb);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mstep_q <= 4'd0;
      rstep_q <= 2'd0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mstep_q <= mstep_d;
      rstep_q <= rstep_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clock) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  always_comb begin
    state_d = state_q;
    mstep_d = mstep_q;
    rstep_d = rstep_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MUL;
          mstep_d = 4'd0;
        end
      end
      S_MUL: begin
        if (mstep_q == LAST_LIMB) begin
          state_d = S_RED;
          rstep_d = 2'd0;
        end else begin
          mstep_d = mstep_q + 4'd1;
        end
      end
      S_RED: begin
        if (rstep_q == LAST_RED) state_d = S_IDLE;
        else                     rstep_d = rstep_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_d = 1'b0;
    out_d  = out_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          acc_d = '0;
        end
      end
      // Stage boundary: accumulate one shifted 255x17 partial product.
      S_MUL: acc_d = acc_q + (510'(pp) << shamt);
      // Stage boundary: reduction reuses the accumulator as scratch.
      S_RED: begin
        case (rstep_q)
          2'd0:    acc_d = 510'(fold_wide(acc_q));
          2'd1:    acc_d = 510'(fold_narrow(acc_q[259:0]));
          2'd2:    acc_d = 510'(canon(acc_q[255:0]));
          default: begin
            out_d  = acc_q[254:0];
            done_d = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_fe_mul.sv
// Randomized and directed bench for fe_mul with a queue scoreboard and a
// wide-integer (a*b) mod p reference model.
module tb_fe_mul;

  localparam logic [254:0] P =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  typedef struct {
    logic [254:0] val;
    int           cyc;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         start;
  logic [254:0] a;
  logic [254:0] b;
  logic         done;
  logic [254:0] out;

  exp_t         q[$];
  int           cyc = 0;
  int           busy_until = 0;
  int           last_e = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  bit           mon_en = 0;
  logic [254:0] model_out = '0;

  fe_mul dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .done  (done),
    .out   (out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [254:0] ref_mul(input logic [254:0] x, input logic [254:0] y);
    logic [509:0] prod;
    logic [509:0] r;
    prod = {255'd0, x} * {255'd0, y};
    r    = prod % {255'd0, P};
    return 255'(r);
  endfunction

  function automatic logic [254:0] rnd255();
    logic [254:0] r;
    int sel;
    sel = $urandom_range(0, 7);
    for (int i = 0; i < 8; i++) r = {r[222:0], 32'($urandom)};
    case (sel)
      0: r = P - 255'(sel + $urandom_range(0, 3));
      1: r = P + 255'($urandom_range(0, 18));
      2: r = '1;
      3: r = 255'($urandom_range(0, 40));
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [254:0] act,
                     input logic [254:0] exp_v);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
  endtask

  // Drives one start pulse; the reference decides whether the DUT accepts it.
  task automatic issue(input logic [254:0] x, input logic [254:0] y, input logic [254:0] exp_v);
    exp_t e;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    last_e = cyc;
    if (cyc >= busy_until) begin
      e.val = exp_v;
      e.cyc = cyc + 19;
      q.push_back(e);
      busy_until = cyc + 20;
    end
    start = 1'b0;
    a = rnd255();
    b = rnd255();
  endtask

  task automatic goto_edge(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  always @(negedge clock) begin
    bit   exp_d;
    exp_t e;
    if (mon_en) begin
      exp_d = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        exp_d = 1'b1;
        model_out = e.val;
      end
      chk(done == exp_d, "done", 255'(done), 255'(exp_d));
      chk(out == model_out, "out", out, model_out);
      if (exp_d) chk(out < P, "canonical", out, P);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [254:0] x, y, la, lb;
    int e0, gap;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    model_out = '0;

    // Directed values with hand-derived results.
    issue(255'd2, 255'd3, 255'd6);
    goto_edge(last_e + 20);
    x = 255'd1 << 254;
    issue(x, 255'd2, 255'd19);
    goto_edge(last_e + 20);
    issue(P - 255'd1, P - 255'd1, 255'd1);
    goto_edge(last_e + 20);
    issue(P - 255'd1, 255'd2, P - 255'd2);
    goto_edge(last_e + 20);
    issue(255'd0, '1, 255'd0);
    goto_edge(last_e + 20);
    issue(P, 255'd5, 255'd0);
    goto_edge(last_e + 20);
    issue(P + 255'd1, 255'd7, 255'd7);
    goto_edge(last_e + 20);
    la = 255'd19074120634824822126221600568435182786804268236321474068950658706909933706558;
    lb = 255'd42341415808548244942861149601678448512076970397948787689406181319388671497316;
    issue(la, lb, ref_mul(la, lb));
    goto_edge(last_e + 20);

    // Starts while busy are dropped; a start in the done cycle is taken.
    x = rnd255();
    y = rnd255();
    issue(x, y, ref_mul(x, y));
    e0 = last_e;
    goto_edge(e0 + 4);
    issue(255'd9, 255'd9, 255'd81);
    goto_edge(e0 + 11);
    issue(255'd4, 255'd4, 255'd16);
    goto_edge(e0 + 19);
    issue(la, x, ref_mul(la, x));
    chk(last_e == e0 + 20, "b2b_edge", 255'(last_e), 255'(e0 + 20));
    goto_edge(e0 + 40);

    // Random operands with random gaps and occasional busy-time starts.
    for (int k = 0; k < 24; k++) begin
      x = rnd255();
      y = rnd255();
      issue(x, y, ref_mul(x, y));
      e0 = last_e;
      if ($urandom_range(0, 2) == 0) begin
        goto_edge(e0 + $urandom_range(1, 17));
        issue(rnd255(), rnd255(), 255'd0);
      end
      gap = $urandom_range(0, 3);
      goto_edge(e0 + 19 + gap);
    end
    goto_edge(last_e + 21);

    // Reset while the multiply is at step 7: no done may follow.
    x = rnd255();
    y = rnd255();
    issue(x, y, ref_mul(x, y));
    e0 = last_e;
    goto_edge(e0 + 7);
    reset = 1'b1;
    @(posedge clock);
    #1;
    q.delete();
    busy_until = 0;
    model_out = '0;
    reset = 1'b0;
    goto_edge(e0 + 40);
    x = rnd255();
    y = rnd255();
    issue(x, y, ref_mul(x, y));

    for (int k = 0; k < 100 && q.size() > 0; k++) @(posedge clock);
    #1;
    @(negedge clock);
    chk(q.size() == 0, "drain", 255'(q.size()), 255'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
